uart_msg_sched: RTL

UART_MSG_SCHED -- requirements
Module: uart_msg_sched

---
 rtl/uart_msg_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_msg_sched.sv
// Streams a zero-terminated message slot from ROM into a byte transmitter, optionally auto-repeating.
// Start to first tx_en is 4 clocks; each byte waits for tx_busy to rise then fall before the next fetch.
module uart_msg_sched #(
    parameter int GAP_CYCLES = 1000,
    parameter int MSG_MAX    = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] switch,
    input  logic       start,
    input  logic       repeat_en,
    input  logic [7:0] rom_q,
    input  logic       tx_busy,
    output logic [9:0] rom_addr,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       msg_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        SEND,
        WAIT_ACK,
        WAIT_IDLE,
        GAP
    } state_t;

    localparam logic [6:0]  IDX_LAST = 7'(MSG_MAX - 1);
    localparam logic [19:0] GAP_LAST = 20'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  sel, sel_nxt;
    logic [6:0]  idx, idx_nxt;
    logic [19:0] gap_cnt, gap_nxt;
    logic [9:0]  rom_addr_nxt;
    logic        tx_en_nxt;
    logic [7:0]  tx_data_nxt;
    logic        msg_done_nxt;
    logic        msg_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= 3'd0;
            idx      <= 7'd0;
            gap_cnt  <= 20'd0;
            rom_addr <= 10'd0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            msg_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            idx      <= idx_nxt;
            gap_cnt  <= gap_nxt;
            rom_addr <= rom_addr_nxt;
            tx_en    <= tx_en_nxt;
            tx_data  <= tx_data_nxt;
            msg_done <= msg_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        idx_nxt      = idx;
        gap_nxt      = gap_cnt;
        rom_addr_nxt = rom_addr;
        tx_en_nxt    = 1'b0;
        tx_data_nxt  = tx_data;
        msg_done_nxt = 1'b0;
        msg_end      = 1'b0;

        case (state)
            IDLE: begin
                if (start || repeat_en) begin
                    sel_nxt      = switch;
                    idx_nxt      = 7'd0;
                    rom_addr_nxt = {switch, 7'd0};
                    state_nxt    = FETCH;
                end
            end
            FETCH: state_nxt = CHECK;
            CHECK: begin
                if (rom_q == 8'h00) begin
                    msg_end = 1'b1;
                end else begin
                    tx_data_nxt = rom_q;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_en_nxt = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                // The last slot byte ends the message rather than wrapping idx.
                if (!tx_busy) begin
                    if (idx == IDX_LAST) begin
                        msg_end = 1'b1;
                    end else begin
                        idx_nxt      = idx + 7'd1;
                        rom_addr_nxt = {sel, idx + 7'd1};
                        state_nxt    = FETCH;
                    end
                end
            end
            GAP: begin
                if (!repeat_en) begin
                    gap_nxt   = 20'd0;
                    state_nxt = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    gap_nxt      = 20'd0;
                    sel_nxt      = switch;
                    idx_nxt      = 7'd0;
                    rom_addr_nxt = {switch, 7'd0};
                    state_nxt    = FETCH;
                end else begin
                    gap_nxt = gap_cnt + 20'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (msg_end) begin
            msg_done_nxt = 1'b1;
            gap_nxt      = 20'd0;
            state_nxt    = repeat_en ? GAP : IDLE;
        end
    end

    assign busy = (state != IDLE);

endmodule
